// File: rtl/syndrome_table_decoder.sv
// Sequential syndrome decoder: computes the syndrome of a received word against
// H_MATRIX, then scans an external error book one entry per cycle for a match.
//
// state    | meaning
// S_IDLE   | waiting for a received word
// S_SYND   | syndrome of latched word evaluated; entry 0 read issued if nonzero
// S_SEARCH | issuing book reads, comparing the entry returned from last cycle
// S_DONE   | result published on the next edge, then held until out_ready

module syndrome_table_decoder #(
  parameter int N          = 16,
  parameter int K          = 5,
  parameter int SYN_W      = 11,
  parameter int BOOK_DEPTH = 697,
  parameter int ADDR_W     = 10,
  parameter logic [SYN_W*N-1:0] H_MATRIX =
    176'h801F_401C_201A_1016_080E_0419_0215_010D_0093_004B_0027
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  output logic              book_rd_en,
  output logic [ADDR_W-1:0] book_addr,
  input  logic [SYN_W-1:0]  book_syn,
  input  logic [N-1:0]      book_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-1:0]      out_msg,
  output logic [N-1:0]      out_code,
  output logic [SYN_W-1:0]  out_syn,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  output logic [ADDR_W:0]   out_search_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SYND, S_SEARCH, S_DONE} state_t;

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(BOOK_DEPTH);
  localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_code, r_err, r_out_code;
  logic [SYN_W-1:0] r_syn, r_out_syn, w_syn;
  logic [ADDR_W:0]  r_addr, r_cnt, r_out_cnt;
  logic             r_corr, r_unc, r_out_corr, r_out_unc, r_out_valid;
  logic             w_accept, w_syn_nz, w_hit, w_last, w_issue;

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_syn_nz   = |w_syn;
  // r_addr is one ahead of the entry whose data is on book_syn/book_err
  assign w_hit      = (r_state == S_SEARCH) && (book_syn == r_syn);
  assign w_last     = (r_addr == L_DEPTH);
  assign w_issue    = (r_state == S_SEARCH) && (r_addr < L_DEPTH);
  assign book_rd_en = ((r_state == S_SYND) && w_syn_nz) || w_issue;
  assign book_addr  = w_issue ? r_addr[ADDR_W-1:0] : '0;

  // s_j lands at bit SYN_W-1-j; codeword position p is bit N-1-p
  always_comb begin
    w_syn = '0;
    for (int j = 0; j < SYN_W; j++) begin
      for (int p = 0; p < N; p++) begin
        w_syn[SYN_W-1-j] = w_syn[SYN_W-1-j] ^ (r_code[N-1-p] & H_MATRIX[j*N+p]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SYND;
      S_SYND:   w_state_nxt = w_syn_nz ? S_SEARCH : S_DONE;
      S_SEARCH: if (w_hit || w_last) w_state_nxt = S_DONE;
      S_DONE:   if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code      <= '0;
      r_syn       <= '0;
      r_addr      <= '0;
      r_err       <= '0;
      r_corr      <= 1'b0;
      r_unc       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_syn   <= '0;
      r_out_corr  <= 1'b0;
      r_out_unc   <= 1'b0;
      r_out_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_code <= in_code;
        end
        S_SYND: begin
          r_syn  <= w_syn;
          r_addr <= L_ONE;
          r_err  <= '0;
          r_corr <= 1'b0;
          r_unc  <= 1'b0;
          r_cnt  <= '0;
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_err  <= book_err;
            r_corr <= 1'b1;
            r_cnt  <= r_addr;
          end else if (w_last) begin
            r_unc <= 1'b1;
            r_cnt <= r_addr;
          end else begin
            r_addr <= r_addr + L_ONE;
          end
        end
        S_DONE: begin
          // staged result is copied out once, so out_* only move with out_valid
          if (!r_out_valid) begin
            r_out_code  <= r_code ^ r_err;
            r_out_syn   <= r_syn;
            r_out_corr  <= r_corr;
            r_out_unc   <= r_unc;
            r_out_cnt   <= r_cnt;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid         = r_out_valid;
  assign out_code          = r_out_code;
  assign out_msg           = r_out_code[N-1:N-K];
  assign out_syn           = r_out_syn;
  assign out_corrected     = r_out_corr;
  assign out_uncorrectable = r_out_unc;
  assign out_search_cnt    = r_out_cnt;

endmodule

// File: doc/syndrome_table_decoder.md
Name: syndrome_table_decoder

Overview:
Parametrised, multi-cycle successor to the combinational RM(1,4) syndrome decoder.
- Accepts one received word per handshake and computes its syndrome against a parameter check matrix.
- Searches an external error-book memory sequentially, one entry per cycle, pipelined.
- Returns the corrected codeword, the systematic message and status flags through a valid/ready output.
- Sits between the channel front end and the message sink; the error book lives in a shared ROM/RAM.

Parameters:
N, 16, codeword length.
K, 5, message length; the message is the first K codeword positions.
SYN_W, 11, syndrome width (N-K).
BOOK_DEPTH, 697, number of error-book entries.
ADDR_W, 10, book address width; must satisfy 2^ADDR_W >= BOOK_DEPTH.
H_MATRIX, RM(1,4) default, SYN_W*N bits; bit (j*N+p) = H[j][p]. Default rows j=0..9: XOR of positions {a,b,c} ^ p(5+j), where {a,b,c} runs over the 3-subsets of {0..4} in lexicographic order. Row 10: p0^p1^p2^p3^p4^p15.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  received word valid
in_ready  out  1  decoder can accept
in_code  in  N  received word; position p = bit N-1-p
book_rd_en  out  1  book read strobe
book_addr  out  ADDR_W  book read address
book_syn  in  SYN_W  syndrome of entry; valid 1 cycle after strobe
book_err  in  N  error pattern of entry; valid 1 cycle after strobe
out_valid  out  1  result valid
out_ready  in  1  sink accepts
out_msg  out  K  corrected message = out_code[N-1:N-K]
out_code  out  N  corrected codeword
out_syn  out  SYN_W  syndrome; s0 at MSB
out_corrected  out  1  nonzero syndrome matched a book entry
out_uncorrectable  out  1  nonzero syndrome, no book match
out_search_cnt  out  ADDR_W+1  book entries compared

Behaviour:
- Reset (async, immediate): state IDLE; in_ready=0 while rst is high, then 1. All out_* are 0, book_rd_en=0, book_addr=0.
- States: IDLE, SYND, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_code and go to SYND.
  - Stall-free: in_ready=0 in all other states.
- SYND (1 cycle):
  - s_j = XOR over p of (r_p & H[j][p]); latch the syndrome.
  - Syndrome zero: go to DONE with out_code=in_code, both flags 0, cnt 0.
  - Otherwise: go to SEARCH, issuing book_addr=0 with book_rd_en=1.
- SEARCH:
  - Issues addresses 0,1,2,... one per cycle while book_rd_en=1.
  - The entry returned 1 cycle later is compared against the latched syndrome.
  - First (lowest-address) match wins: error=book_err, out_corrected=1, go to DONE.
  - The in-flight next read is discarded, and book_rd_en drops the cycle after the match.
  - Reads are never issued beyond BOOK_DEPTH-1.
  - If entry BOOK_DEPTH-1 misses: out_uncorrectable=1, error=0, out_code=raw word, go to DONE.
  - out_search_cnt = number of entries compared: a+1 on a match at address a, BOOK_DEPTH on a miss.
- DONE:
  - out_valid=1; all out_* held stable until out_ready.
  - On out_valid&out_ready, go to IDLE; out_valid falls next cycle.
  - out_* values persist until the next result.
- Latency, counted in clock edges after the accept edge to out_valid high:
  - zero syndrome: 2
  - match at address a: a+3
  - miss: BOOK_DEPTH+2
- Book entry with syndrome 0 is never matched; the zero-syndrome path bypasses the search.
- out_corrected and out_uncorrectable are never both 1.
- rst asserted mid-search or mid-DONE aborts and discards the result; no partial output is emitted.
- Arithmetic: out_code = latched word XOR error; all XOR reductions are width-exact.

Test Plan:
1. Clean word: in_code=16'h24DB → out_valid 2 edges after accept, out_code=16'h24DB, out_msg=5'h04, out_syn=0, both flags 0, cnt=0, book_rd_en never asserted.
2. Single-bit error at position 0:
   - Stimulus: in_code=16'hA4DB; book entry 5 = {syn 11'h7E1, err 16'h8000}; entries 0-4 nonmatching.
   - Response: out_syn=11'h7E1, out_code=16'h24DB, out_msg=5'h04, out_corrected=1, cnt=6, out_valid 8 edges after accept.
3. Miss with BOOK_DEPTH=8 and no matching entry → out_uncorrectable=1, out_code=raw input, cnt=8, out_valid 10 edges after accept, and book_addr never exceeds 7.
4. Duplicate match, same syndrome at addresses 2 and 4 → the address-2 error pattern is applied, cnt=3.
5. Backpressure: out_ready=0 for 20 cycles after out_valid → outputs stable, in_ready=0 throughout, and a pending in_valid is accepted only after the out_ready handshake.
6. rst pulse during SEARCH at address 3 → outputs 0 immediately; after release the next word decodes correctly with no stale flags.
